// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler that time-shares one sequential multiplier core among N_REQ requesters.
// A requester holds req until gnt; the product returns with a one-cycle rsp_valid bit on its lane.
module mult_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   op_a,
    input  logic [N_REQ*DW-1:0]   op_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [2*DW-1:0]       rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    output logic                  mul_start,
    input  logic                  mul_done,
    input  logic [2*DW-1:0]       mul_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     last, idx, sel_idx;
    logic              sel_vld;
    logic [CW-1:0]     cnt;
    logic              timeout_hit;
    logic [N_REQ-1:0]  gnt_nx, rsp_valid_nx;
    logic              mul_start_nx, busy_nx;

    // Scan last+1, last+2, ... so the most recently served requester ranks lowest.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!sel_vld && req[(int'(last) + k) % N_REQ]) begin
                sel_vld = 1'b1;
                sel_idx = IW'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // mul_done is deliberately ignored in ISSUE so a level held from the last job cannot leak through.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (sel_vld) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (mul_done || timeout_hit) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_nx       = gnt;
        rsp_valid_nx = '0;
        mul_start_nx = 1'b0;
        busy_nx      = (state_nx != S_IDLE);
        if (state == S_IDLE && sel_vld) begin
            gnt_nx       = N_REQ'(1) << sel_idx;
            mul_start_nx = 1'b1;
        end
        if (state == S_WAIT && state_nx == S_RESP) rsp_valid_nx = N_REQ'(1) << idx;
        if (state == S_RESP) gnt_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            last      <= IW'(N_REQ - 1);
            idx       <= '0;
            cnt       <= '0;
        end else begin
            gnt       <= gnt_nx;
            rsp_valid <= rsp_valid_nx;
            busy      <= busy_nx;
            mul_start <= mul_start_nx;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        idx   <= sel_idx;
                        mul_a <= op_a[sel_idx*DW +: DW];
                        mul_b <= op_b[sel_idx*DW +: DW];
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (mul_done) begin
                        rsp_data <= mul_result;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: last <= idx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a behavioural multiplier core and a response scoreboard.
module tb_mult_rr_scheduler;

    localparam int N_REQ   = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;
    localparam int RW      = N_REQ + 1 + 2*DW;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] op_a, op_b;
    logic [N_REQ-1:0]    gnt, rsp_valid;
    logic [2*DW-1:0]     rsp_data;
    logic                rsp_err, busy;
    logic [DW-1:0]       mul_a, mul_b;
    logic                mul_start;
    logic                mul_done = 1'b0;
    logic [2*DW-1:0]     mul_result = '0;

    mult_rr_scheduler #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_rsp(input int i, input logic err, input logic [2*DW-1:0] d);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return {v, err, d};
    endfunction

    // behavioural core: done rises core_delay WAIT cycles after start; level mode holds done until next start
    int               core_delay = 1;
    int               core_cnt   = 0;
    bit               core_hang  = 1'b0;
    bit               core_level = 1'b0;
    bit               core_run   = 1'b0;
    bit               core_pend  = 1'b0;
    logic [2*DW-1:0]  core_prod  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            core_run  = 1'b0;
            core_pend = 1'b0;
            mul_done  = 1'b0;
        end else begin
            if (core_pend) begin
                core_pend = 1'b0;
                core_run  = 1'b0;
                mul_done  = 1'b0;
                core_prod = (2*DW)'(mul_a) * (2*DW)'(mul_b);
                if (!core_hang) begin
                    if (core_delay <= 1) begin
                        mul_done   = 1'b1;
                        mul_result = core_prod;
                    end else begin
                        core_cnt = core_delay - 1;
                        core_run = 1'b1;
                    end
                end
            end else if (core_run) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_run   = 1'b0;
                    mul_done   = 1'b1;
                    mul_result = core_prod;
                end
            end else if (!core_level) begin
                mul_done   = 1'b0;
                mul_result = 32'hDEAD_BEEF;
            end
            if (mul_start) core_pend = 1'b1;
        end
    end

    // scoreboard / monitor
    int start_cnt    = 0;
    int last_rsp_cyc = 0;
    bit prev_start   = 1'b0;

    always @(negedge clk) begin
        if (mul_start) begin
            start_cnt++;
            chk("start_single", 64'(prev_start), 64'd0);
        end
        prev_start = mul_start;
        if (rsp_valid != '0) begin
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else chk("rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_a[i*DW +: DW] = a;
        op_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_start(output logic [N_REQ-1:0] g, output int t);
        g = '0;
        t = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mul_start) begin
                g = gnt;
                t = cyc;
                return;
            end
        end
        chk("start_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                chk("drain", 64'(exp_q.size()), 64'd0);
                return;
            end
        end
        chk("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench did not finish");
    end

    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] gs[5];
    int               ts[5];
    int               t, s0;
    logic [N_REQ-1:0] order[5];

    initial begin
        req  = '0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt",       64'(gnt),       64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_mul_a",     64'(mul_a),     64'd0);
        chk("rst_mul_b",     64'(mul_b),     64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        rst = 1'b1;

        // single request, core done after 16 cycles
        set_ops(0, 16'd3, 16'd5);
        core_delay = 16;
        exp_q.push_back(exp_rsp(0, 1'b0, 32'd15));
        s0  = start_cnt;
        req = 4'b0001;
        wait_start(g, t);
        chk("t1_gnt",  64'(g),    64'h1);
        chk("t1_busy", 64'(busy), 64'd1);
        req = '0;
        wait_idle();
        chk("t1_latency", 64'(last_rsp_cyc - t), 64'd17);
        chk("t1_starts",  64'(start_cnt - s0),   64'd1);

        // all four continuously requesting, zero-wait core
        do_reset();
        core_delay = 1;
        set_ops(0, 16'hFFFF, 16'hFFFF);
        set_ops(1, 16'h0002, 16'h0003);
        set_ops(2, 16'h1234, 16'h0010);
        set_ops(3, 16'h8000, 16'h0002);
        exp_q.push_back(exp_rsp(0, 1'b0, 32'hFFFE_0001));
        exp_q.push_back(exp_rsp(1, 1'b0, 32'h0000_0006));
        exp_q.push_back(exp_rsp(2, 1'b0, 32'h0001_2340));
        exp_q.push_back(exp_rsp(3, 1'b0, 32'h0001_0000));
        exp_q.push_back(exp_rsp(0, 1'b0, 32'hFFFE_0001));
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_start(gs[k], ts[k]);
        req = '0;
        wait_idle();
        for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), 64'(gs[k]), 64'(order[k]));
        chk("t2_period", 64'(ts[1] - ts[0]), 64'd4);

        // req=1010 with last=1 grants 3 then 1; 1 alone afterwards
        core_delay = 2;
        set_ops(1, 16'd7, 16'd9);
        set_ops(3, 16'h00FF, 16'h0101);
        exp_q.push_back(exp_rsp(1, 1'b0, 32'd63));
        req = 4'b0010;
        wait_start(g, t);
        chk("t3_setup_gnt", 64'(g), 64'h2);
        req = '0;
        wait_idle();
        exp_q.push_back(exp_rsp(3, 1'b0, 32'h0000_FFFF));
        exp_q.push_back(exp_rsp(1, 1'b0, 32'd63));
        req = 4'b1010;
        wait_start(g, t);
        chk("t3_first_gnt", 64'(g), 64'h8);
        req = 4'b0010;
        wait_start(g, t);
        chk("t3_second_gnt", 64'(g), 64'h2);
        req = '0;
        wait_idle();
        exp_q.push_back(exp_rsp(1, 1'b0, 32'd63));
        req = 4'b0010;
        wait_start(g, t);
        chk("t3_alone_gnt", 64'(g), 64'h2);
        req = '0;
        wait_idle();

        // hung core times out, next request served normally
        core_hang = 1'b1;
        exp_q.push_back(exp_rsp(2, 1'b1, 32'd0));
        req = 4'b0100;
        wait_start(g, t);
        chk("t4_gnt", 64'(g), 64'h4);
        req = '0;
        wait_idle();
        chk("t4_latency", 64'(last_rsp_cyc - t), 64'd65);
        core_hang  = 1'b0;
        core_delay = 3;
        exp_q.push_back(exp_rsp(2, 1'b0, 32'h0001_2340));
        req = 4'b0100;
        wait_start(g, t);
        chk("t4_retry_gnt", 64'(g), 64'h4);
        req = '0;
        wait_idle();
        chk("t4_retry_latency", 64'(last_rsp_cyc - t), 64'd4);

        // reset during WAIT aborts silently and restores the pointer
        core_delay = 16;
        set_ops(0, 16'd4, 16'd4);
        exp_q.push_back(exp_rsp(0, 1'b0, 32'd16));
        req = 4'b0001;
        wait_start(g, t);
        req = '0;
        wait_idle();
        req = 4'b0001;
        wait_start(g, t);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_gnt",       64'(gnt),       64'd0);
        chk("t5_busy",      64'(busy),      64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_mul_start", 64'(mul_start), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        set_ops(1, 16'd5, 16'd6);
        exp_q.push_back(exp_rsp(0, 1'b0, 32'd16));
        req = 4'b0011;
        wait_start(g, t);
        chk("t5_after_rst_gnt", 64'(g), 64'h1);
        req = '0;
        wait_idle();

        // operands latched at grant; done held high across jobs is masked
        core_level = 1'b1;
        core_delay = 4;
        set_ops(1, 16'd11, 16'd13);
        exp_q.push_back(exp_rsp(1, 1'b0, 32'd143));
        req = 4'b0010;
        wait_start(g, t);
        req = '0;
        set_ops(1, 16'd99, 16'd13);
        wait_idle();
        chk("t6_latency", 64'(last_rsp_cyc - t), 64'd5);
        core_delay = 5;
        exp_q.push_back(exp_rsp(1, 1'b0, 32'd1287));
        req = 4'b0010;
        wait_start(g, t);
        req = '0;
        wait_idle();
        chk("t6_stale_done_latency", 64'(last_rsp_cyc - t), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
